rossler_frame_tx: RTL and testbench
===================================

// Module: rossler_frame_tx
// PURPOSE
//  Consumer of the rossler oscillator state outputs (xn/yn/zn, Q11.21 two's complement, Width=32).
//  - Captures every Decim-th sample strobe and buffers whole (x,y,z) triplets in a small FIFO.
//  - Serialises each triplet as a framed byte stream over a valid/ready interface, feeding the UART/host link.
//  - Sits between the oscillator core and the byte transmitter on the FPGA top level.
// PARAMETERS
//  Width      32     sample width; must be a multiple of 8
//  Decim      1      capture 1 of every Decim sample strobes (>=1)
//  FifoDepth  4      triplet FIFO depth; power of 2, >=2
//  SyncByte   8'hA5  frame start marker
// PORTS
//  clk_i           in   1        single clock
//  rst_i           in   1        asynchronous, active-low reset
//  enable_i        in   1        capture enable
//  sample_valid_i  in   1        one-cycle strobe; xn/yn/zn are valid in this cycle
//  xn_i            in   Width    state x
//  yn_i            in   Width    state y
//  zn_i            in   Width    state z
//  tdata_o         out  8        frame byte
//  tvalid_o        out  1        tdata_o valid
//  tready_i        in   1        downstream accepts byte when tvalid_o&tready_i
//  overflow_o      out  1        sticky; a captured sample was dropped (FIFO full)
//  drop_cnt_o      out  16       dropped-sample count, saturating at 16'hFFFF
//  busy_o          out  1        FSM not IDLE or FIFO not empty
// BEHAVIOUR
//  Reset: all outputs 0, FIFO empty, decimation counter 0, FSM IDLE.
//  - Reset is asynchronous: it takes effect mid-frame with tvalid_o low immediately. No partial frame resumes.
//  Decimation: counter increments on sample_valid_i&enable_i.
//  - At count==Decim-1 the sample is captured and the counter wraps to 0.
//  - With Decim=1, every strobe is captured. enable_i low freezes the counter.
//  Capture: writes {xn_i,yn_i,zn_i} to the FIFO in the strobe cycle.
//  - If the FIFO is full, the sample is dropped: overflow_o is set and drop_cnt_o is incremented.
//  - Full with a simultaneous pop in the same cycle: the write is accepted, no drop.
//  Frame: 2+3*Width/8 bytes = SyncByte, x[MSB..LSB], y[MSB..LSB], z[MSB..LSB], CSUM.
//  - CSUM is the XOR of all data bytes; SyncByte is excluded.
//  FSM:
//  - IDLE->SYNC when the FIFO is non-empty; pops the head into the frame shift register.
//  - SYNC->DATA on handshake.
//  - DATA: byte index 0..3*Width/8-1, advancing on each handshake; ->CSUM after the last index.
//  - CSUM->IDLE on handshake. The next frame starts the following cycle, with no gap byte.
//  Handshake: once tvalid_o rises, tvalid_o and tdata_o hold until tready_i is seen high.
//  - tvalid_o is low only in IDLE.
//  Latency: strobe at cycle N with FIFO empty and FSM IDLE gives FIFO write at N, pop at N+1, SyncByte on tdata_o with tvalid_o=1 at N+2.
//  Capacity: FifoDepth triplets in the FIFO plus 1 in the shift register.
//  enable_i low: stops capture only. Buffered frames and the frame in flight drain completely.
//  overflow_o and drop_cnt_o clear only on reset.
// STRUCTURE
//  rossler_pkg:
//  - FRAC_BITS=21 and SYNC_BYTE.
//  - FRAME_BYTES(Width) function.
//  - FSM state encoding (IDLE/SYNC/DATA/CSUM, 2-bit).
//  Sub-module sync_fifo (Width*3 data, FifoDepth entries, full/empty, same-cycle push+pop when full).
//  Top-level contents: decimation counter, FSM, shift register, byte index, running-XOR checksum register.
// TESTING
//  1. Single frame, Decim=1, tready_i=1. Stimulus x=32'h00200000, y=32'hFFE00000, z=32'h00100000.
//     -> bytes A5 00 20 00 00 FF E0 00 00 00 10 00 00 2F; tvalid_o first high 2 cycles after the strobe.
//  2. Back-pressure: tready_i toggled at random over the frame from test 1.
//     -> identical 14-byte sequence; tdata_o stable while tvalid_o&!tready_i.
//  3. Decimation: Decim=4, 8 strobes with x=1..8 (y,z=0).
//     -> exactly 2 frames, carrying x=4 then x=8.
//  4. Overflow: FifoDepth=4, tready_i=0, 6 strobes.
//     -> 5 accepted, overflow_o=1, drop_cnt_o=1; releasing tready_i yields 5 frames in order.
//  5. Reset mid-frame: assert rst_i low after byte 5.
//     -> tvalid_o=0 asynchronously, busy_o=0, overflow_o=0; the next strobe produces a complete fresh frame.
//  6. Streaming: Decim=1, a strobe every 20 cycles, tready_i=1, 1000 strobes.
//     -> 1000 frames, no drops, checksums correct, decoded values match the inputs.

Source files
------------

// File: rtl/rossler_pkg.sv
// Shared definitions for the rossler oscillator frame transmitter.
//   FRAC_BITS   : fractional bits of the Q11.21 state samples
//   SYNC_BYTE   : default frame start marker
//   FRAME_BYTES : total bytes per frame for a given sample width
//   state_e     : transmitter FSM encoding
package rossler_pkg;

  localparam int       FRAC_BITS = 21;
  localparam bit [7:0] SYNC_BYTE = 8'hA5;

  // sync + three samples + checksum
  function automatic int FRAME_BYTES(input int w);
    return 2 + 3 * w / 8;
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SYNC = 2'd1,
    ST_DATA = 2'd2,
    ST_CSUM = 2'd3
  } state_e;

endpackage

// File: rtl/rossler_frame_tx_fifo.sv
// Synchronous FIFO holding captured (x,y,z) triplets.
//   clk, rst_n  : clock, async active-low reset
//   push / din  : write request and data (ignored when full unless popping)
//   pop / dout  : read request and head-of-queue data (fall-through)
//   full, empty : occupancy flags
// A push while full is accepted when a pop happens in the same cycle.
module sync_fifo #(
  parameter int W     = 96,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wp, rp;
  logic         do_push, do_pop;

  // extra pointer MSB distinguishes full from empty
  assign empty   = (wp == rp);
  assign full    = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rp[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wp[AW-1:0]] <= din;
  end

endmodule

// File: rtl/rossler_frame_tx.sv
// Frames decimated rossler oscillator samples into a byte stream.
//   clk_i, rst_i         : clock, async active-low reset
//   enable_i             : capture enable (draining continues when low)
//   sample_valid_i       : one-cycle strobe qualifying xn_i/yn_i/zn_i
//   tdata_o/tvalid_o     : frame byte stream, held until tready_i
//   tready_i             : downstream ready
//   overflow_o           : sticky, a captured sample found the FIFO full
//   drop_cnt_o           : saturating count of dropped samples
//   busy_o               : frame in flight or samples buffered
// Frame: SyncByte, x, y, z (MSB byte first), XOR of the data bytes.
module rossler_frame_tx
  import rossler_pkg::*;
#(
  parameter int       Width     = 32,
  parameter int       Decim     = 1,
  parameter int       FifoDepth = 4,
  parameter bit [7:0] SyncByte  = SYNC_BYTE
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             enable_i,
  input  logic             sample_valid_i,
  input  logic [Width-1:0] xn_i,
  input  logic [Width-1:0] yn_i,
  input  logic [Width-1:0] zn_i,
  output logic [7:0]       tdata_o,
  output logic             tvalid_o,
  input  logic             tready_i,
  output logic             overflow_o,
  output logic [15:0]      drop_cnt_o,
  output logic             busy_o
);

  localparam int TW  = 3 * Width;
  localparam int NB  = FRAME_BYTES(Width) - 2;  // data bytes per frame
  localparam int IW  = $clog2(NB);
  localparam int DCW = (Decim > 1) ? $clog2(Decim) : 1;

  state_e          state, state_nxt;
  logic [DCW-1:0]  dcnt;
  logic [TW-1:0]   sreg;
  logic [IW-1:0]   idx;
  logic [7:0]      csum;
  logic [TW-1:0]   fifo_dout;
  logic            fifo_full, fifo_empty;
  logic            strobe, cap, pop, drop, hs;
  logic [7:0]      cur_byte;

  assign strobe   = sample_valid_i && enable_i;
  assign cap      = strobe && (dcnt == DCW'(Decim - 1));
  assign pop      = (state == ST_IDLE) && !fifo_empty;
  // a pop in the same cycle frees the slot, so that write is not a drop
  assign drop     = cap && fifo_full && !pop;
  assign hs       = tvalid_o && tready_i;
  assign cur_byte = sreg[TW-1 -: 8];

  sync_fifo #(.W(TW), .DEPTH(FifoDepth)) u_fifo (
    .clk   (clk_i),
    .rst_n (rst_i),
    .push  (cap),
    .din   ({xn_i, yn_i, zn_i}),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // decimation counter
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)      dcnt <= '0;
    else if (cap)    dcnt <= '0;
    else if (strobe) dcnt <= dcnt + DCW'(1);
  end

  // drop accounting
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      overflow_o <= 1'b0;
      drop_cnt_o <= '0;
    end else if (drop) begin
      overflow_o <= 1'b1;
      if (drop_cnt_o != 16'hFFFF) drop_cnt_o <= drop_cnt_o + 16'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    tvalid_o  = 1'b1;
    tdata_o   = 8'h00;
    case (state)
      ST_IDLE: begin
        tvalid_o = 1'b0;
        if (pop) state_nxt = ST_SYNC;
      end
      ST_SYNC: begin
        tdata_o = SyncByte;
        if (tready_i) state_nxt = ST_DATA;
      end
      ST_DATA: begin
        tdata_o = cur_byte;
        if (tready_i && idx == IW'(NB - 1)) state_nxt = ST_CSUM;
      end
      ST_CSUM: begin
        tdata_o = csum;
        if (tready_i) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // shift register, byte index and running checksum
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      sreg <= '0;
      idx  <= '0;
      csum <= '0;
    end else if (pop) begin
      sreg <= fifo_dout;
      idx  <= '0;
      csum <= '0;
    end else if (hs && state == ST_DATA) begin
      sreg <= {sreg[TW-9:0], 8'h00};
      idx  <= idx + IW'(1);
      csum <= csum ^ cur_byte;
    end
  end

  assign busy_o = (state != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_rossler_frame_tx.sv
module tb_rossler_frame_tx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en1 = 1'b0, en4 = 1'b0, sv = 1'b0;
  logic [31:0] x = '0, y = '0, z = '0;
  logic        tready = 1'b1;
  int          rmode = 0;        // 0: ready, 1: random, 2: stalled

  logic [7:0]  td1, td4;
  logic        tv1, tv4, ov1, ov4, b1, b4;
  logic [15:0] dc1, dc4;

  always #5 clk = ~clk;

  rossler_frame_tx #(.Width(32), .Decim(1), .FifoDepth(4)) u_dut (
    .clk_i(clk), .rst_i(rst_n), .enable_i(en1), .sample_valid_i(sv),
    .xn_i(x), .yn_i(y), .zn_i(z), .tdata_o(td1), .tvalid_o(tv1),
    .tready_i(tready), .overflow_o(ov1), .drop_cnt_o(dc1), .busy_o(b1));

  rossler_frame_tx #(.Width(32), .Decim(4), .FifoDepth(4)) u_dut4 (
    .clk_i(clk), .rst_i(rst_n), .enable_i(en4), .sample_valid_i(sv),
    .xn_i(x), .yn_i(y), .zn_i(z), .tdata_o(td4), .tvalid_o(tv4),
    .tready_i(tready), .overflow_o(ov4), .drop_cnt_o(dc4), .busy_o(b4));

  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) begin
    #1;
    case (rmode)
      0:       tready = 1'b1;
      1:       tready = 1'($urandom_range(0, 1));
      default: tready = 1'b0;
    endcase
  end

  // scoreboard + byte monitor (one DUT at a time, chosen by sel)
  logic [95:0] sbq[$];
  logic        sel = 1'b0;
  int          fcnt = 0, nframes = 0;
  logic [7:0]  fb[14];
  logic        prev_stall = 1'b0;
  logic [7:0]  prev_data = '0;
  wire  [7:0]  mtd = sel ? td4 : td1;
  wire         mtv = sel ? tv4 : tv1;

  always @(negedge clk) begin
    if (!rst_n) begin
      fcnt = 0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", mtv, 1'b1);
        chk("hold_data", mtd, prev_data);
      end
      prev_stall = mtv && !tready;
      prev_data  = mtd;
      if (mtv && tready) begin
        fb[fcnt] = mtd;
        fcnt++;
        if (fcnt == 14) begin
          logic [95:0] e, got;
          logic [7:0]  cs;
          fcnt = 0;
          nframes++;
          if (sbq.size() == 0) begin
            chk("unexpected_frame", 1, 0);
          end else begin
            e = sbq.pop_front();
            got = '0;
            cs = '0;
            for (int i = 1; i <= 12; i++) got = {got[87:0], fb[i]};
            for (int i = 0; i < 12; i++) cs = cs ^ e[95 - 8*i -: 8];
            chk("sync", fb[0], 8'hA5);
            chk("data", got, e);
            chk("csum", fb[13], cs);
          end
        end
      end
    end
  end

  task automatic strobe(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c, input bit expect_cap);
    @(posedge clk); #1;
    x = a; y = b; z = c; sv = 1'b1;
    if (expect_cap) sbq.push_back({a, b, c});
    @(posedge clk); #1;
    sv = 1'b0;
  endtask

  task automatic drain(input int budget);
    bit done = 0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #2;
      if (sbq.size() == 0 && !b1 && !b4 && fcnt == 0) begin
        done = 1;
        break;
      end
    end
    chk("drain_done", done, 1'b1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    logic [31:0] r0, r1, r2;

    // reset state
    #1;
    chk("rst_tvalid", tv1, 0);
    chk("rst_tdata", td1, 0);
    chk("rst_ovf", ov1, 0);
    chk("rst_drop", dc1, 0);
    chk("rst_busy", b1, 0);
    @(negedge clk); rst_n = 1'b1;
    en1 = 1'b1;

    // 1: single frame, latency
    n0 = nframes;
    @(posedge clk); #1;
    x = 32'h00200000; y = 32'hFFE00000; z = 32'h00100000; sv = 1'b1;
    sbq.push_back({x, y, z});
    @(posedge clk); #1;
    sv = 1'b0;
    chk("lat_n1_tvalid", tv1, 0);
    @(posedge clk); #1;
    chk("lat_n2_tvalid", tv1, 1);
    chk("lat_n2_tdata", td1, 8'hA5);
    drain(100);
    chk("t1_frames", nframes - n0, 1);

    // 2: back-pressure
    rmode = 1;
    n0 = nframes;
    strobe(32'h00200000, 32'hFFE00000, 32'h00100000, 1);
    drain(400);
    chk("t2_frames", nframes - n0, 1);
    rmode = 0;

    // 3: decimation by 4
    en1 = 1'b0; en4 = 1'b1; sel = 1'b1;
    n0 = nframes;
    for (int i = 1; i <= 8; i++) strobe(32'(i), 0, 0, (i % 4) == 0);
    drain(200);
    chk("t3_frames", nframes - n0, 2);
    en4 = 1'b0; sel = 1'b0; en1 = 1'b1;

    // 4: overflow with stalled sink
    rmode = 2;
    @(posedge clk); #2;
    n0 = nframes;
    for (int i = 0; i < 6; i++) strobe(32'h100 + 32'(i), 32'(i), ~32'(i), i < 5);
    chk("t4_overflow", ov1, 1);
    chk("t4_drop_cnt", dc1, 1);
    chk("t4_busy", b1, 1);
    chk("t4_stall_valid", tv1, 1);
    rmode = 0;
    drain(400);
    chk("t4_frames", nframes - n0, 5);
    chk("t4_ovf_sticky", ov1, 1);

    // 5: reset mid-frame
    strobe($urandom, $urandom, $urandom, 1);
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #2;
      if (fcnt >= 5) break;
    end
    chk("t5_reached_byte5", fcnt >= 5, 1);
    rst_n = 1'b0;
    #1;
    chk("t5_tvalid", tv1, 0);
    chk("t5_busy", b1, 0);
    chk("t5_ovf", ov1, 0);
    chk("t5_drop", dc1, 0);
    sbq.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    n0 = nframes;
    strobe(32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF, 1);
    drain(100);
    chk("t5_frames", nframes - n0, 1);

    // 6: streaming
    n0 = nframes;
    for (int i = 0; i < 1000; i++) begin
      r0 = $urandom; r1 = $urandom; r2 = $urandom;
      strobe(r0, r1, r2, 1);
      repeat (18) @(posedge clk);
    end
    drain(200);
    chk("t6_frames", nframes - n0, 1000);
    chk("t6_drop", dc1, 0);
    chk("t6_ovf", ov1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
